csr_unit_m: RTL and testbench
=============================

Name: csr_unit_m

Overview:
- Next-generation machine-mode CSR unit for the RV32IMA+Zicsr core.
- Adds WARL field masking, illegal-access detection and trap entry/MRET state updates.
- Adds interrupt-pending generation and 64-bit mcycle/minstret counters with an inhibit control.
- Sits beside the execute stage. Reads are combinational; all state commits on the clock edge.

Parameters:
- HART_ID, 0: value returned by mhartid.
- VENDOR_ID, 0: value returned by mvendorid.
- MTVEC_RESET, 32'h0000_0000: reset value of mtvec (bits [1:0] forced 0).
- CNT_W, 64: counter width, 33..64; bits above CNT_W read as 0.
- NUM_HPM, 2: number of mhpmcounter3.. / mhpmevent3.. pairs when CSR_HPM_EN is defined, 0..8.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- csr_valid  in  1  CSR instruction in execute this cycle
- csr_op  in  3  funct3: RW=001, RS=010, RC=011, RWI=101, RSI=110, RCI=111
- csr_addr  in  12  CSR address
- csr_rs1_val  in  32  rs1 register value
- csr_uimm  in  5  zimm field; also acts as rs1 index for the "rs1==x0" test
- csr_rd_nz  in  1  rd != x0
- csr_rdata  out  32  old CSR value, valid in the same cycle
- csr_illegal  out  1  illegal CSR access this cycle
- trap_valid  in  1  take trap this cycle
- trap_cause  in  32  mcause value; bit31 = interrupt
- trap_epc  in  32  faulting PC
- trap_tval  in  32  mtval value
- mret  in  1  MRET retiring
- instret_inc  in  1  one instruction retired
- hpm_event  in  NUM_HPM  per-counter event pulses
- irq_mtip, irq_msip, irq_meip  in  1 each  interrupt lines
- trap_vector  out  32  PC of the trap handler for the current trap_cause
- mepc_out  out  32  current mepc
- irq_pending  out  1  enabled interrupt pending

Behaviour:
- Reset (async, rst=1): all CSRs 0, except:
  - mtvec = MTVEC_RESET & ~3
  - misa = MXL 01, I bit set
  - mstatus.MPP = 2'b11
  - Outputs are 0, except mepc_out=0 and trap_vector=MTVEC_RESET & ~3.
- Operand: src = csr_rs1_val for ops 001..011; {27'b0, csr_uimm} for 101..111.
- Write enable (we):
  - RW/RWI: always write.
  - RS/RC/RSI/RCI: write only if csr_uimm != 0.
- Read side effect: RW/RWI with csr_rd_nz=0 perform no read; csr_rdata = 0.
- New value:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
  - Then apply the WARL mask.
- WARL masks:
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] is hardwired 11.
  - mtvec: bit1 forced 0; MODE[0] is writable.
  - mepc: [1:0] forced 0.
  - mie / mip: only bits 3, 7, 11 are implemented.
  - mip is read-only; writes are ignored but legal.
  - misa, mvendorid, marchid, mimpid, mhartid: writes are ignored.
- Illegal access (csr_illegal=1, no state change, csr_rdata=0):
  - address not implemented, or
  - we=1 and csr_addr[11:10]==2'b11 (read-only space).
- Counters (mcycle/mcycleh, minstret/minstreth):
  - Low half is at 0xB00/0xB02; high half is at 0xB80/0xB82.
  - User shadows 0xC00/0xC02/0xC80/0xC82 are read-only.
  - mcountinhibit (0x320): bit0 = CY, bit2 = IR.
  - mcycle increments every cycle unless CY is set.
  - minstret increments on instret_inc unless IR is set.
  - Wrap-around: all-ones -> 0.
  - A CSR write to either half takes priority over the increment in that cycle. The other half holds.
  - The increment of a CSR instruction's own retirement is suppressed when that instruction writes the counter.
- mip: bits MSIP/MTIP/MEIP are registered from the irq_* lines (1-cycle latency).
- irq_pending: mstatus.MIE & |(mip & mie), combinational from registers.
- Trap entry (trap_valid=1), committed at the edge:
  - mepc = trap_epc & ~3
  - mcause = trap_cause
  - mtval = trap_tval
  - MPIE = MIE, MIE = 0
- trap_vector:
  - base = mtvec & ~3.
  - If mtvec[0]=1 and trap_cause[31]=1: base + 4*trap_cause[4:0].
  - Otherwise: base.
- MRET: MIE = MPIE, MPIE = 1.
- Priority when several events occur in one cycle: trap_valid > mret > CSR write. The lower-priority update is dropped entirely; counter increments still occur.
- csr_valid=0: csr_rdata=0, csr_illegal=0.

Optional Feature:
- CSR_HPM_EN defined:
  - mhpmcounter3..(3+NUM_HPM-1) and their h-halves are implemented, with mhpmevent3.. (1-bit enable each).
  - A counter increments when hpm_event[i] & mhpmevent[i] & ~mcountinhibit[3+i].
- CSR_HPM_EN undefined:
  - Addresses 0xB03..0xB1F, 0xB83..0xB9F and 0x323..0x33F read 0, accept writes with no effect, and are legal.
  - hpm_event is unused.

Decomposition:
- csr_pkg gains:
  - CSR address constants (counters, mcountinhibit, hpm)
  - csr_op_t enum
  - mstatus/mip bit-position constants
  - WARL mask constants
  - interrupt cause codes 3/7/11
- One sub-module, csr_counter: CNT_W-bit counter with inc, low/high write ports and wrap. Instantiated for mcycle, minstret and each HPM counter.

Test Plan:
- Reset, then read misa, mstatus, mtvec -> 0x40000100, 0x00001800, MTVEC_RESET & ~3; csr_illegal=0.
- CSRRS mstatus with rs1=0xFFFFFFFF -> mstatus reads 0x00001888. CSRRC with rs1=0x8 -> 0x00001880.
- Write mcycle=0xFFFFFFFF and mcycleh=0xFFFFFFFF, then idle 2 cycles -> mcycle=1, mcycleh=0. Set mcountinhibit=1 -> the value freezes.
- CSRRW to 0xF11 (mvendorid) -> csr_illegal=1, no change. CSRRS 0xF11 with uimm=0 -> legal, reads VENDOR_ID.
- mtvec=0x80000001, mie=0x80, mstatus.MIE=1, pulse irq_mtip:
  - irq_pending=1 one cycle later.
  - trap_valid with cause 0x80000007 -> trap_vector=0x8000001C, MIE=0, MPIE=1, mepc=trap_epc & ~3.
  - Then mret -> MIE=1.
- trap_valid, mret and a CSRRW to mscratch all in the same cycle -> only the trap updates; mscratch is unchanged.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR unit.
// Holds CSR addresses, the funct3 encoding, mstatus/mip bit positions and WARL masks.
package csr_pkg;

    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } csr_op_t;

    localparam logic [11:0] ADDR_MSTATUS       = 12'h300;
    localparam logic [11:0] ADDR_MISA          = 12'h301;
    localparam logic [11:0] ADDR_MIE           = 12'h304;
    localparam logic [11:0] ADDR_MTVEC         = 12'h305;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_MHPMEVENT3    = 12'h323;
    localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
    localparam logic [11:0] ADDR_MEPC          = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE        = 12'h342;
    localparam logic [11:0] ADDR_MTVAL         = 12'h343;
    localparam logic [11:0] ADDR_MIP           = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] ADDR_MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;
    localparam logic [11:0] ADDR_MVENDORID     = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID       = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID        = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID       = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // Interrupt cause codes double as the mip/mie bit positions.
    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;
    localparam int IRQ_MEI = 11;

    localparam logic [31:0] MIE_MASK          = 32'h0000_0888;
    localparam logic [31:0] MTVEC_MASK        = ~32'h0000_0002;
    localparam logic [31:0] MEPC_MASK         = ~32'h0000_0003;
    localparam logic [31:0] MISA_VALUE        = 32'h4000_0100;
    localparam logic [31:0] INHIBIT_BASE_MASK = 32'h0000_0005;

endpackage

// File: rtl/csr_counter.sv
// CNT_W-bit event counter exposed as two 32-bit CSR halves.
// A write to one half wins over the increment and leaves the other half untouched.
module csr_counter #(
    parameter int CNT_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [31:0] rd_lo,
    output logic [31:0] rd_hi
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (wr_lo) begin
            cnt <= {cnt[CNT_W-1:32], wdata};
        end else if (wr_hi) begin
            cnt <= CNT_W'({wdata, cnt[31:0]});
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign rd_lo = cnt[31:0];
    assign rd_hi = 32'(cnt >> 32);

endmodule

// File: rtl/csr_unit_m.sv
// Machine-mode CSR unit: WARL CSRs, illegal-access detection, trap/MRET, interrupts, counters.
// Define CSR_HPM_EN to implement mhpmcounter3.. and mhpmevent3.. (otherwise they read 0).
module csr_unit_m
    import csr_pkg::*;
#(
    parameter int          HART_ID     = 0,
    parameter int          VENDOR_ID   = 0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          CNT_W       = 64,
    parameter int          NUM_HPM     = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   csr_valid,
    input  logic [2:0]                             csr_op,
    input  logic [11:0]                            csr_addr,
    input  logic [31:0]                            csr_rs1_val,
    input  logic [4:0]                             csr_uimm,
    input  logic                                   csr_rd_nz,
    output logic [31:0]                            csr_rdata,
    output logic                                   csr_illegal,
    input  logic                                   trap_valid,
    input  logic [31:0]                            trap_cause,
    input  logic [31:0]                            trap_epc,
    input  logic [31:0]                            trap_tval,
    input  logic                                   mret,
    input  logic                                   instret_inc,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
    input  logic                                   irq_mtip,
    input  logic                                   irq_msip,
    input  logic                                   irq_meip,
    output logic [31:0]                            trap_vector,
    output logic [31:0]                            mepc_out,
    output logic                                   irq_pending
);

    localparam int HPM_SZ = (NUM_HPM > 0) ? NUM_HPM : 1;
`ifdef CSR_HPM_EN
    localparam logic [31:0] INHIBIT_MASK = INHIBIT_BASE_MASK | (((32'd1 << NUM_HPM) - 32'd1) << 3);
`else
    localparam logic [31:0] INHIBIT_MASK = INHIBIT_BASE_MASK;
`endif

    csr_op_t     op;
    logic        is_write_op;
    logic [31:0] src;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic [31:0] hpm_rd;
    logic        hpm_range;
    logic        hit;
    logic        we;
    logic        rd_en;
    logic        illegal;
    logic        commit;

    logic        mst_mie;
    logic        mst_mpie;
    logic [31:0] mie_q;
    logic [31:0] mip_q;
    logic [31:0] mtvec_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [31:0] mscratch_q;
    logic [31:0] inhibit_q;
    logic [31:0] mstatus_rd;
    logic [31:0] vec_base;

    logic [31:0] cyc_lo, cyc_hi, ins_lo, ins_hi;

    assign op          = csr_op_t'(csr_op);
    assign is_write_op = (csr_op[1:0] == 2'b01);
    assign src         = csr_op[2] ? {27'b0, csr_uimm} : csr_rs1_val;
    assign we          = csr_valid & (is_write_op | (csr_uimm != 5'd0));
    assign rd_en       = csr_valid & (csr_rd_nz | ~is_write_op);
    assign mstatus_rd  = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};

    // Unused HPM CSR windows stay legal and read as zero.
    assign hpm_range = ((csr_addr[11:5] == 7'h58) || (csr_addr[11:5] == 7'h5C) ||
                        (csr_addr[11:5] == 7'h19)) && (csr_addr[4:0] >= 5'd3);

    always_comb begin
        hit     = 1'b1;
        old_val = '0;
        case (csr_addr)
            ADDR_MSTATUS:              old_val = mstatus_rd;
            ADDR_MISA:                 old_val = MISA_VALUE;
            ADDR_MIE:                  old_val = mie_q;
            ADDR_MTVEC:                old_val = mtvec_q;
            ADDR_MCOUNTINHIBIT:        old_val = inhibit_q;
            ADDR_MSCRATCH:             old_val = mscratch_q;
            ADDR_MEPC:                 old_val = mepc_q;
            ADDR_MCAUSE:               old_val = mcause_q;
            ADDR_MTVAL:                old_val = mtval_q;
            ADDR_MIP:                  old_val = mip_q;
            ADDR_MVENDORID:            old_val = 32'(VENDOR_ID);
            ADDR_MARCHID, ADDR_MIMPID: old_val = '0;
            ADDR_MHARTID:              old_val = 32'(HART_ID);
            ADDR_MCYCLE, ADDR_CYCLE:       old_val = cyc_lo;
            ADDR_MCYCLEH, ADDR_CYCLEH:     old_val = cyc_hi;
            ADDR_MINSTRET, ADDR_INSTRET:   old_val = ins_lo;
            ADDR_MINSTRETH, ADDR_INSTRETH: old_val = ins_hi;
            default: begin
                hit     = hpm_range;
                old_val = hpm_rd;
            end
        endcase
    end

    always_comb begin
        case (op)
            CSR_RW, CSR_RWI: new_val = src;
            CSR_RS, CSR_RSI: new_val = old_val | src;
            CSR_RC, CSR_RCI: new_val = old_val & ~src;
            default:         new_val = old_val;
        endcase
    end

    // funct3 000/100 are not CSR ops and are flagged rather than silently ignored.
    assign illegal = csr_valid & (~hit | (we & (csr_addr[11:10] == 2'b11)) |
                                  (csr_op[1:0] == 2'b00));
    assign commit  = we & ~illegal & ~trap_valid & ~mret;

    assign csr_rdata   = (rd_en & ~illegal) ? old_val : '0;
    assign csr_illegal = illegal;
    assign mepc_out    = mepc_q;
    assign irq_pending = mst_mie & (|(mip_q & mie_q));

    assign vec_base    = mtvec_q & ~32'd3;
    assign trap_vector = (mtvec_q[0] & trap_cause[31]) ?
                         vec_base + {25'b0, trap_cause[4:0], 2'b00} : vec_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= MTVEC_RESET & ~32'd3;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mscratch_q <= '0;
            inhibit_q  <= '0;
        end else begin
            mip_q <= (32'(irq_msip) << IRQ_MSI) | (32'(irq_mtip) << IRQ_MTI) |
                     (32'(irq_meip) << IRQ_MEI);
            if (trap_valid) begin
                mepc_q   <= trap_epc & MEPC_MASK;
                mcause_q <= trap_cause;
                mtval_q  <= trap_tval;
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
            end else if (mret) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
            end else if (commit) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        mst_mie  <= new_val[MSTATUS_MIE];
                        mst_mpie <= new_val[MSTATUS_MPIE];
                    end
                    ADDR_MIE:           mie_q      <= new_val & MIE_MASK;
                    ADDR_MTVEC:         mtvec_q    <= new_val & MTVEC_MASK;
                    ADDR_MCOUNTINHIBIT: inhibit_q  <= new_val & INHIBIT_MASK;
                    ADDR_MSCRATCH:      mscratch_q <= new_val;
                    ADDR_MEPC:          mepc_q     <= new_val & MEPC_MASK;
                    ADDR_MCAUSE:        mcause_q   <= new_val;
                    ADDR_MTVAL:         mtval_q    <= new_val;
                    default: ;
                endcase
            end
        end
    end

    csr_counter #(.CNT_W(CNT_W)) u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (~inhibit_q[0]),
        .wr_lo (commit && (csr_addr == ADDR_MCYCLE)),
        .wr_hi (commit && (csr_addr == ADDR_MCYCLEH)),
        .wdata (new_val),
        .rd_lo (cyc_lo),
        .rd_hi (cyc_hi)
    );

    csr_counter #(.CNT_W(CNT_W)) u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instret_inc & ~inhibit_q[2]),
        .wr_lo (commit && (csr_addr == ADDR_MINSTRET)),
        .wr_hi (commit && (csr_addr == ADDR_MINSTRETH)),
        .wdata (new_val),
        .rd_lo (ins_lo),
        .rd_hi (ins_hi)
    );

`ifdef CSR_HPM_EN
    logic [HPM_SZ-1:0] hpm_ev_q;
    logic [31:0]       hpm_lo [HPM_SZ];
    logic [31:0]       hpm_hi [HPM_SZ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hpm_ev_q <= '0;
        end else begin
            for (int i = 0; i < NUM_HPM; i++) begin
                if (commit && (csr_addr == ADDR_MHPMEVENT3 + 12'(i))) hpm_ev_q[i] <= new_val[0];
            end
        end
    end

    always_comb begin
        hpm_rd = '0;
        for (int i = 0; i < NUM_HPM; i++) begin
            if (csr_addr == ADDR_MHPMCOUNTER3 + 12'(i))  hpm_rd = hpm_lo[i];
            if (csr_addr == ADDR_MHPMCOUNTER3H + 12'(i)) hpm_rd = hpm_hi[i];
            if (csr_addr == ADDR_MHPMEVENT3 + 12'(i))    hpm_rd = {31'b0, hpm_ev_q[i]};
        end
    end

    for (genvar g = 0; g < NUM_HPM; g++) begin : g_hpm
        csr_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (hpm_event[g] & hpm_ev_q[g] & ~inhibit_q[3+g]),
            .wr_lo (commit && (csr_addr == ADDR_MHPMCOUNTER3 + 12'(g))),
            .wr_hi (commit && (csr_addr == ADDR_MHPMCOUNTER3H + 12'(g))),
            .wdata (new_val),
            .rd_lo (hpm_lo[g]),
            .rd_hi (hpm_hi[g])
        );
    end
`else
    logic unused_hpm;
    assign unused_hpm = ^hpm_event;
    assign hpm_rd     = '0;
`endif

endmodule

// File: tb/tb_csr_unit_m.sv
// Self-checking bench for csr_unit_m: directed plan cases plus randomized traffic
// compared every cycle against an architectural CSR model.
module tb_csr_unit_m;

    localparam logic [31:0] MTVEC_RESET = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_valid;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_rs1_val;
    logic [4:0]  csr_uimm;
    logic        csr_rd_nz;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] trap_tval;
    logic        mret;
    logic        instret_inc;
    logic [1:0]  hpm_event;
    logic        irq_mtip, irq_msip, irq_meip;
    logic [31:0] trap_vector;
    logic [31:0] mepc_out;
    logic        irq_pending;

    csr_unit_m #(
        .HART_ID     (0),
        .VENDOR_ID   (0),
        .MTVEC_RESET (MTVEC_RESET),
        .CNT_W       (64),
        .NUM_HPM     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_valid   (csr_valid),
        .csr_op      (csr_op),
        .csr_addr    (csr_addr),
        .csr_rs1_val (csr_rs1_val),
        .csr_uimm    (csr_uimm),
        .csr_rd_nz   (csr_rd_nz),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .trap_valid  (trap_valid),
        .trap_cause  (trap_cause),
        .trap_epc    (trap_epc),
        .trap_tval   (trap_tval),
        .mret        (mret),
        .instret_inc (instret_inc),
        .hpm_event   (hpm_event),
        .irq_mtip    (irq_mtip),
        .irq_msip    (irq_msip),
        .irq_meip    (irq_meip),
        .trap_vector (trap_vector),
        .mepc_out    (mepc_out),
        .irq_pending (irq_pending)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard
    typedef struct {
        int          sel;
        logic [31:0] val;
    } lit_t;

    logic [97:0] exp_q[$];
    lit_t        lit_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // architectural model
    bit          m_mie_bit, m_mpie_bit;
    logic [31:0] m_mie, m_mip, m_mtvec, m_mepc, m_mcause, m_mtval, m_scratch, m_inh;
    logic [63:0] m_cycle, m_instret;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_mie_bit  = 0;
        m_mpie_bit = 0;
        m_mie      = 0;
        m_mip      = 0;
        m_mtvec    = MTVEC_RESET & ~32'd3;
        m_mepc     = 0;
        m_mcause   = 0;
        m_mtval    = 0;
        m_scratch  = 0;
        m_inh      = 0;
        m_cycle    = 0;
        m_instret  = 0;
    endfunction

    function automatic bit model_read(input logic [11:0] a, output logic [31:0] v);
        bit hit = 1;
        v = 0;
        case (a)
            12'h300: v = 32'h1800 | (m_mpie_bit ? 32'h80 : 0) | (m_mie_bit ? 32'h8 : 0);
            12'h301: v = 32'h4000_0100;
            12'h304: v = m_mie;
            12'h305: v = m_mtvec;
            12'h320: v = m_inh;
            12'h340: v = m_scratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = m_mip;
            12'hF11, 12'hF12, 12'hF13, 12'hF14: v = 0;
            12'hB00, 12'hC00: v = m_cycle[31:0];
            12'hB80, 12'hC80: v = m_cycle[63:32];
            12'hB02, 12'hC02: v = m_instret[31:0];
            12'hB82, 12'hC82: v = m_instret[63:32];
            default: hit = (a >= 12'hB03 && a <= 12'hB1F) || (a >= 12'hB83 && a <= 12'hB9F) ||
                           (a >= 12'h323 && a <= 12'h33F);
        endcase
        return hit;
    endfunction

    // compare process
    always @(negedge clk) begin
        logic [97:0] e;
        lit_t        l;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rdata", csr_rdata, e[97:66]);
            chk("illegal", {31'b0, csr_illegal}, {31'b0, e[65]});
            chk("trap_vector", trap_vector, e[64:33]);
            chk("mepc_out", mepc_out, e[32:1]);
            chk("irq_pending", {31'b0, irq_pending}, {31'b0, e[0]});
        end
        while (lit_q.size() > 0) begin
            l = lit_q.pop_front();
            case (l.sel)
                0: chk("lit_rdata", csr_rdata, l.val);
                1: chk("lit_illegal", {31'b0, csr_illegal}, l.val);
                2: chk("lit_trap_vector", trap_vector, l.val);
                3: chk("lit_mepc_out", mepc_out, l.val);
                default: chk("lit_irq_pending", {31'b0, irq_pending}, l.val);
            endcase
        end
    end

    // driver tasks
    task automatic idle();
        csr_valid   = 0; csr_op = 3'b010; csr_addr = 0; csr_rs1_val = 0; csr_uimm = 0;
        csr_rd_nz   = 0; trap_valid = 0; trap_cause = 0; trap_epc = 0; trap_tval = 0;
        mret        = 0; instret_inc = 0; hpm_event = 0;
        irq_mtip    = 0; irq_msip = 0; irq_meip = 0;
    endtask

    task automatic set_csr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] rs1,
                           input logic [4:0] uimm, input logic rdnz);
        csr_valid = 1; csr_op = op; csr_addr = a; csr_rs1_val = rs1; csr_uimm = uimm; csr_rd_nz = rdnz;
    endtask

    task automatic lit(input int sel, input logic [31:0] val);
        lit_t l;
        l.sel = sel;
        l.val = val;
        lit_q.push_back(l);
    endtask

    task automatic rd(input logic [11:0] a);
        set_csr(3'b010, a, 32'h0, 5'd0, 1'b1);
    endtask

    // Called just after a rising edge with inputs set for this cycle; commits the model for the next edge.
    task automatic run();
        logic [31:0] v, src, nv, rdv, tv;
        logic [63:0] oc, oi;
        bit hit, we, ill, rw, commit;
        hit = model_read(csr_addr, v);
        rw  = (csr_op == 3'b001) || (csr_op == 3'b101);
        src = csr_op[2] ? 32'(csr_uimm) : csr_rs1_val;
        we  = rw || (csr_uimm != 0);
        ill = csr_valid && (!hit || (we && csr_addr[11:10] == 2'b11));
        rdv = (csr_valid && !ill && !(rw && !csr_rd_nz)) ? v : 32'h0;
        tv  = m_mtvec & ~32'd3;
        if (m_mtvec[0] && trap_cause[31]) tv = tv + 32'(trap_cause[4:0]) * 4;
        exp_q.push_back({rdv, ill, tv, m_mepc, m_mie_bit && ((m_mip & m_mie) != 0)});

        if (rw) nv = src;
        else if (csr_op[1:0] == 2'b10) nv = v | src;
        else nv = v & ~src;
        commit = csr_valid && we && !ill && !trap_valid && !mret;
        oc = m_cycle;
        oi = m_instret;
        if (!m_inh[0]) m_cycle = m_cycle + 1;
        if (instret_inc && !m_inh[2]) m_instret = m_instret + 1;
        m_mip = (irq_msip ? 32'h8 : 0) | (irq_mtip ? 32'h80 : 0) | (irq_meip ? 32'h800 : 0);
        if (trap_valid) begin
            m_mepc     = trap_epc & ~32'd3;
            m_mcause   = trap_cause;
            m_mtval    = trap_tval;
            m_mpie_bit = m_mie_bit;
            m_mie_bit  = 0;
        end else if (mret) begin
            m_mie_bit  = m_mpie_bit;
            m_mpie_bit = 1;
        end else if (commit) begin
            case (csr_addr)
                12'h300: begin m_mie_bit = nv[3]; m_mpie_bit = nv[7]; end
                12'h304: m_mie     = nv & 32'h888;
                12'h305: m_mtvec   = nv & ~32'h2;
                12'h320: m_inh     = nv & 32'h5;
                12'h340: m_scratch = nv;
                12'h341: m_mepc    = nv & ~32'd3;
                12'h342: m_mcause  = nv;
                12'h343: m_mtval   = nv;
                12'hB00: m_cycle   = {oc[63:32], nv};
                12'hB80: m_cycle   = {nv, oc[31:0]};
                12'hB02: m_instret = {oi[63:32], nv};
                12'hB82: m_instret = {nv, oi[31:0]};
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    logic [11:0] addrs [0:27] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14,
                                  12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80,
                                  12'hC82, 12'hB05, 12'hB9F, 12'h33F, 12'h321, 12'h7C0, 12'hC03};
    logic [2:0]  ops [0:5] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    initial begin
        idle();
        model_reset();
        lit(0, 32'h0); lit(1, 32'h0); lit(2, MTVEC_RESET & ~32'd3); lit(3, 32'h0); lit(4, 32'h0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 0;

        // reset readback
        rd(12'h301); lit(0, 32'h4000_0100); lit(1, 32'h0); run();
        rd(12'h300); lit(0, 32'h0000_1800); run();
        rd(12'h305); lit(0, MTVEC_RESET & ~32'd3); run();

        // mstatus set / clear
        set_csr(3'b010, 12'h300, 32'hFFFF_FFFF, 5'd1, 1'b0); run();
        rd(12'h300); lit(0, 32'h0000_1888); run();
        set_csr(3'b011, 12'h300, 32'h0000_0008, 5'd1, 1'b0); run();
        rd(12'h300); lit(0, 32'h0000_1880); run();

        // 64-bit wrap, then inhibit
        set_csr(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd1, 1'b0); run();
        set_csr(3'b001, 12'hB80, 32'hFFFF_FFFF, 5'd1, 1'b0); run();
        run();
        run();
        rd(12'hB00); lit(0, 32'h1); run();
        rd(12'hB80); lit(0, 32'h0); run();
        set_csr(3'b101, 12'h320, 32'h0, 5'd1, 1'b0); run();
        rd(12'hB00); lit(0, 32'h4); run();
        rd(12'hB00); lit(0, 32'h4); run();
        set_csr(3'b101, 12'h320, 32'h0, 5'd0, 1'b0); run();

        // read-only space
        set_csr(3'b001, 12'hF11, 32'h1234, 5'd3, 1'b1); lit(1, 32'h1); lit(0, 32'h0); run();
        set_csr(3'b010, 12'hF11, 32'h0, 5'd0, 1'b1); lit(1, 32'h0); lit(0, 32'h0); run();

        // vectored interrupt trap and MRET
        set_csr(3'b001, 12'h305, 32'h8000_0001, 5'd1, 1'b0); run();
        set_csr(3'b001, 12'h304, 32'h0000_0080, 5'd1, 1'b0); run();
        set_csr(3'b110, 12'h300, 32'h0, 5'd8, 1'b0); run();
        irq_mtip = 1; lit(4, 32'h0); run();
        lit(4, 32'h1); run();
        trap_valid = 1; trap_cause = 32'h8000_0007; trap_epc = 32'h0000_1235; trap_tval = 32'hDEAD;
        lit(2, 32'h8000_001C); run();
        rd(12'h300); lit(0, 32'h0000_1880); lit(3, 32'h0000_1234); run();
        mret = 1; run();
        rd(12'h300); lit(0, 32'h0000_1888); run();

        // trap beats mret beats CSR write
        set_csr(3'b001, 12'h340, 32'h55, 5'd1, 1'b0); run();
        set_csr(3'b001, 12'h340, 32'hAAAA, 5'd1, 1'b0);
        trap_valid = 1; mret = 1; trap_cause = 32'h2; trap_epc = 32'h400;
        lit(2, 32'h8000_0000); run();
        rd(12'h340); lit(0, 32'h55); lit(3, 32'h400); run();
        rd(12'h300); lit(0, 32'h0000_1880); run();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            csr_valid   = ($urandom_range(0, 3) != 0);
            csr_op      = ops[$urandom_range(0, 5)];
            csr_addr    = addrs[$urandom_range(0, 27)];
            csr_rs1_val = $urandom();
            csr_uimm    = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom());
            csr_rd_nz   = 1'($urandom_range(0, 1));
            trap_valid  = ($urandom_range(0, 15) == 0);
            trap_cause  = $urandom();
            trap_epc    = $urandom();
            trap_tval   = $urandom();
            mret        = ($urandom_range(0, 15) == 0);
            instret_inc = 1'($urandom_range(0, 1));
            hpm_event   = 2'($urandom());
            irq_mtip    = ($urandom_range(0, 3) == 0);
            irq_msip    = ($urandom_range(0, 3) == 0);
            irq_meip    = ($urandom_range(0, 3) == 0);
            run();
        end

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, 0 required", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
